// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU result port, LSU load port, register-file
// write port, hazard query port and queue occupancy.
interface wb_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 64
) ();

   logic                  alu_valid;
   logic [4:0]            alu_rd;
   logic [DATA_WIDTH-1:0] alu_data;
   logic                  alu_stall;

   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [4:0]            lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_data;

   logic                  W_en;
   logic [4:0]            Rd;
   logic [DATA_WIDTH-1:0] Wr_data;

   logic [4:0]            chk_rs1;
   logic [4:0]            chk_rs2;
   logic                  pend1;
   logic                  pend2;

   logic [2:0]            lq_count;

   // Arbiter side
   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             chk_rs1, chk_rs2,
      output alu_stall, lsu_ready, W_en, Rd, Wr_data, pend1, pend2, lq_count
   );

   // Pipeline / register-file side
   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             chk_rs1, chk_rs2,
      input  alu_stall, lsu_ready, W_en, Rd, Wr_data, pend1, pend2, lq_count
   );

endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and load results onto a single
// register-file write port. Losing loads wait in a small FIFO; a starving
// queue head stalls the ALU until it drains.
module wb_arbiter #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned LQ_DEPTH     = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic         clk,
   input logic         rst_n,
   wb_arbiter_if.slave bus
);

   localparam int unsigned PW = (LQ_DEPTH > 2) ? 2 : 1;
   localparam int unsigned CW = 3;
   localparam int unsigned AW = 4;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_ALU  = 2'd1;
   localparam logic [1:0] SRC_HEAD = 2'd2;
   localparam logic [1:0] SRC_LSU  = 2'd3;

   logic [4:0]            q_rd   [LQ_DEPTH];
   logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic [AW-1:0]         age;

   logic                  w_en;
   logic [4:0]            rd_q;
   logic [DATA_WIDTH-1:0] wr_data_q;

   logic                  empty_c;
   logic                  stall_c;
   logic                  ready_c;
   logic                  accept_c;
   logic                  push_c;
   logic                  pop_c;
   logic                  win_c;
   logic                  write_c;
   logic [1:0]            sel_c;
   logic [4:0]            win_rd_c;
   logic [DATA_WIDTH-1:0] win_data_c;
   logic [PW-1:0]         off_c;
   logic                  hit1_c;
   logic                  hit2_c;

   assign empty_c  = (count == '0);
   assign stall_c  = !empty_c && (age >= AW'(STARVE_LIMIT));
   assign ready_c  = (count < CW'(LQ_DEPTH));
   assign accept_c = bus.lsu_valid && ready_c;

   // Pick this cycle's winner in priority order and mux its payload
   always_comb begin
      sel_c      = SRC_NONE;
      win_rd_c   = '0;
      win_data_c = '0;
      if (stall_c)             sel_c = SRC_HEAD;
      else if (bus.alu_valid)  sel_c = SRC_ALU;
      else if (!empty_c)       sel_c = SRC_HEAD;
      else if (accept_c)       sel_c = SRC_LSU;
      case (sel_c)
         SRC_ALU: begin
            win_rd_c   = bus.alu_rd;
            win_data_c = bus.alu_data;
         end
         SRC_HEAD: begin
            win_rd_c   = q_rd[rd_ptr];
            win_data_c = q_data[rd_ptr];
         end
         SRC_LSU: begin
            win_rd_c   = bus.lsu_rd;
            win_data_c = bus.lsu_data;
         end
         default: ;
      endcase
   end

   assign win_c   = (sel_c != SRC_NONE);
   assign write_c = win_c && (win_rd_c != 5'd0);
   assign pop_c   = (sel_c == SRC_HEAD);
   assign push_c  = accept_c && (sel_c != SRC_LSU);

   // Queue pointers, occupancy and head age
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         age    <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_c) - CW'(pop_c);
         if (pop_c || empty_c)   age <= '0;
         else if (age != AW'(15)) age <= age + AW'(1);
      end
   end

   // Queue storage; contents are qualified by count so need no reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         q_rd[wr_ptr]   <= bus.lsu_rd;
         q_data[wr_ptr] <= bus.lsu_data;
      end
   end

   // Register-file write stage; Rd/Wr_data hold when nothing is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_en      <= 1'b0;
         rd_q      <= '0;
         wr_data_q <= '0;
      end else begin
         w_en <= write_c;
         if (write_c) begin
            rd_q      <= win_rd_c;
            wr_data_q <= win_data_c;
         end
      end
   end

   // Hazard lookup across live queue entries
   always_comb begin
      off_c  = '0;
      hit1_c = 1'b0;
      hit2_c = 1'b0;
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
         off_c = PW'(i) - rd_ptr;
         if (CW'(off_c) < count) begin
            if (q_rd[i] == bus.chk_rs1) hit1_c = 1'b1;
            if (q_rd[i] == bus.chk_rs2) hit2_c = 1'b1;
         end
      end
   end

   assign bus.pend1 = (bus.chk_rs1 != 5'd0) && (hit1_c || (w_en && (rd_q == bus.chk_rs1)));
   assign bus.pend2 = (bus.chk_rs2 != 5'd0) && (hit2_c || (w_en && (rd_q == bus.chk_rs2)));

   assign bus.alu_stall = stall_c;
   assign bus.lsu_ready = ready_c;
   assign bus.lq_count  = count;
   assign bus.W_en      = w_en;
   assign bus.Rd        = rd_q;
   assign bus.Wr_data   = wr_data_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of all write-back data.
REQ-002 Parameter LQ_DEPTH, default 2, load-queue entries; legal values 2 or 4.
REQ-003 Parameter STARVE_LIMIT, default 4, cycles a queued load may wait before forcing an ALU stall; range 1..15.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 alu_valid  in  1  ALU result present this cycle; no backpressure.
REQ-007 alu_rd  in  5  ALU destination register index.
REQ-008 alu_data  in  DATA_WIDTH  ALU result.
REQ-009 lsu_valid  in  1  load result offered.
REQ-010 lsu_ready  out  1  load queue can accept; transfer when lsu_valid & lsu_ready.
REQ-011 lsu_rd  in  5  load destination index.
REQ-012 lsu_data  in  DATA_WIDTH  load data.
REQ-013 alu_stall  out  1  upstream SHALL hold alu_valid low while this is high.
REQ-014 W_en  out  1  register-file write enable.
REQ-015 Rd  out  5  register-file write index.
REQ-016 Wr_data  out  DATA_WIDTH  register-file write data.
REQ-017 chk_rs1, chk_rs2  in  5 each  hazard-query indices.
REQ-018 pend1, pend2  out  1 each  query index has a write pending in queue or output stage.
REQ-019 lq_count  out  3  current queue occupancy.

Function
REQ-020 W_en, Rd, Wr_data SHALL be registered on posedge clk; a winning source appears on them exactly 1 cycle after it is presented/accepted.
REQ-021 Per-cycle winner priority: (1) queue head if alu_stall=1 and queue non-empty; (2) ALU if alu_valid=1; (3) queue head if non-empty; (4) accepted load, bypassing the queue, if the queue is empty; (5) none -> W_en=0 next cycle.
REQ-022 An accepted load that does not win SHALL be pushed to the queue tail the same edge; push and pop in one cycle SHALL both occur, leaving lq_count unchanged.
REQ-023 lsu_ready = (lq_count < LQ_DEPTH), purely from registered count; no same-cycle pop credit.
REQ-024 Queue SHALL be FIFO with wrapping read/write pointers; loads SHALL be written to the register file in acceptance order.
REQ-025 Destination index 0 from either source SHALL still win/consume its slot but drive W_en=0 for that cycle; Rd/Wr_data then don't-care.
REQ-026 Age counter: reset to 0 on any pop or when queue empty; else increments each cycle the head loses, saturating at 15.
REQ-027 alu_stall = queue non-empty and age >= STARVE_LIMIT.
REQ-028 If alu_valid=1 while alu_stall=1 (protocol violation), queue head SHALL still win and ALU result is dropped; no other state corrupted.
REQ-029 pendN = 1 when chk_rsN != 0 and it equals the rd of any valid queue entry or equals Rd while W_en=1; combinational.
REQ-030 Output register holds its last Rd/Wr_data when W_en=0; only W_en deasserts.

Reset
REQ-031 On rst_n low, immediately: W_en=0, Rd=0, Wr_data=0, lq_count=0, pointers=0, age=0; thus lsu_ready=1, alu_stall=0, pend1=pend2=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued loads with no write issued; first write after release takes REQ-020 latency.

Verification
REQ-033 ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle N -> W_en=1, Rd=5, Wr_data=0x1234 at cycle N+1; lq_count=0.
REQ-034 Collision: alu (rd=3) and load (rd=7, 0xAA) same cycle -> cycle+1 writes x3; cycle+2 writes x7=0xAA; lq_count 1 then 0; pend on chk_rs1=7 high during the wait.
REQ-035 Full: alu_valid held 1 with LQ_DEPTH=2 loads accepted -> lq_count=2, lsu_ready=0; third load held by LSU until a pop frees a slot.
REQ-036 Starvation: alu_valid continuous, one load queued, STARVE_LIMIT=4 -> alu_stall rises after 4 lost cycles; queue head written next cycle; alu_stall then falls.
REQ-037 x0: load with lsu_rd=0 alone -> consumed, W_en stays 0, lq_count stays 0.
REQ-038 Reset mid-run: 2 entries queued, pulse rst_n low -> W_en=0, lq_count=0, lsu_ready=1 immediately; queued loads never written.
